// File: rtl/swb.sv
// rtl/swb.sv - sparse write buffer: in-order allocate, out-of-order write-back, in-order retire
module swb #(
  parameter int DATA_WIDTH = 32,
  parameter int SWB_DEPTH  = 8,
  localparam int IW = $clog2(SWB_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  output logic [IW-1:0]         alloc_idx,
  input  logic                  wb_valid,
  input  logic [IW-1:0]         wb_idx,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  retire_valid,
  input  logic                  retire_ready,
  output logic [IW-1:0]         retire_idx,
  output logic [DATA_WIDTH-1:0] retire_data,
  output logic [SWB_DEPTH-1:0]  entry_alloc,
  output logic [SWB_DEPTH-1:0]  entry_done,
  output logic [IW-1:0]         head_id,
  output logic [IW:0]           count
);

  localparam logic [IW:0] FULL_COUNT = (IW+1)'(SWB_DEPTH);

  logic [IW-1:0]         head;
  logic [IW-1:0]         tail;
  logic [DATA_WIDTH-1:0] data [SWB_DEPTH];

  logic alloc_fire;
  logic wb_accept;
  logic retire_fire;

  // Full blocks allocation even while retiring, so alloc_ready never sees retire_ready.
  assign alloc_ready  = (count != FULL_COUNT);
  assign alloc_idx    = tail;
  assign retire_valid = (count != '0) && entry_done[head];
  assign retire_idx   = head;
  assign head_id      = head;
  assign retire_data  = data[head];

  assign alloc_fire  = alloc_valid && alloc_ready;
  assign wb_accept   = wb_valid && entry_alloc[wb_idx] && !entry_done[wb_idx];
  assign retire_fire = retire_valid && retire_ready;

  // Alloc, write-back and retire never touch the same entry in one cycle:
  // tail is unallocated, and the retiring head is already done.
  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      entry_alloc <= '0;
      entry_done  <= '0;
      for (int i = 0; i < SWB_DEPTH; i++) begin
        data[i] <= '0;
      end
    end else begin
      if (alloc_fire) begin
        entry_alloc[tail] <= 1'b1;
        entry_done[tail]  <= 1'b0;
        tail              <= tail + IW'(1);
      end
      if (wb_accept) begin
        data[wb_idx]       <= wb_data;
        entry_done[wb_idx] <= 1'b1;
      end
      if (retire_fire) begin
        entry_alloc[head] <= 1'b0;
        entry_done[head]  <= 1'b0;
        head              <= head + IW'(1);
      end
      case ({alloc_fire, retire_fire})
        2'b10:   count <= count + (IW+1)'(1);
        2'b01:   count <= count - (IW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_swb.sv
// tb/tb_swb.sv - directed vector table plus randomized run against a queue-based reference model
module tb_swb;

  localparam int DW = 32;
  localparam int D  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid;
  logic          alloc_ready;
  logic [IW-1:0] alloc_idx;
  logic          wb_valid;
  logic [IW-1:0] wb_idx;
  logic [DW-1:0] wb_data;
  logic          retire_valid;
  logic          retire_ready;
  logic [IW-1:0] retire_idx;
  logic [DW-1:0] retire_data;
  logic [D-1:0]  entry_alloc;
  logic [D-1:0]  entry_done;
  logic [IW-1:0] head_id;
  logic [IW:0]   count;

  swb #(.DATA_WIDTH(DW), .SWB_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
    .retire_valid(retire_valid), .retire_ready(retire_ready),
    .retire_idx(retire_idx), .retire_data(retire_data),
    .entry_alloc(entry_alloc), .entry_done(entry_done),
    .head_id(head_id), .count(count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    bit          rst, av, wv;
    int          widx;
    logic [31:0] wdata;
    bit          rr;
    bit          ar;
    int          aidx;
    bit          rv;
    int          ridx;
    logic [31:0] rdata;
    int          cnt;
    logic [7:0]  ea, ed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit av, bit wv, int widx, logic [31:0] wd, bit rr,
                              bit ar, int aidx, bit rv, int ridx, logic [31:0] rd,
                              int cnt, logic [7:0] ea, logic [7:0] ed);
    vec_t v;
    v.rst = r; v.av = av; v.wv = wv; v.widx = widx; v.wdata = wd; v.rr = rr;
    v.ar = ar; v.aidx = aidx; v.rv = rv; v.ridx = ridx; v.rdata = rd;
    v.cnt = cnt; v.ea = ea; v.ed = ed;
    return v;
  endfunction

  // Reference model: ordered list of live entries, oldest first.
  typedef struct {
    int          idx;
    bit          done;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  int   m_tail;

  task automatic model_step(input bit r, input bit av, input bit wv, input int widx,
                            input logic [31:0] wd, input bit rr);
    bit can_alloc, can_ret;
    if (r) begin
      mq.delete();
      m_tail = 0;
      return;
    end
    can_alloc = mq.size() < D;
    can_ret   = mq.size() > 0 && mq[0].done;
    if (wv) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].idx == widx && !mq[i].done) begin
          mq[i].done = 1'b1;
          mq[i].data = wd;
        end
      end
    end
    if (can_ret && rr) void'(mq.pop_front());
    if (av && can_alloc) begin
      mq.push_back('{idx: m_tail, done: 1'b0, data: '0});
      m_tail = (m_tail + 1) % D;
    end
  endtask

  task automatic model_check();
    logic [7:0] ea, ed;
    bit rv;
    ea = '0;
    ed = '0;
    foreach (mq[i]) begin
      ea[mq[i].idx] = 1'b1;
      if (mq[i].done) ed[mq[i].idx] = 1'b1;
    end
    rv = mq.size() > 0 && mq[0].done;
    chk("rnd_alloc_ready", alloc_ready, mq.size() < D);
    chk("rnd_alloc_idx", alloc_idx, m_tail);
    chk("rnd_count", count, mq.size());
    chk("rnd_entry_alloc", entry_alloc, ea);
    chk("rnd_entry_done", entry_done, ed);
    chk("rnd_retire_valid", retire_valid, rv);
    chk("rnd_retire_idx", retire_idx, mq.size() > 0 ? mq[0].idx : m_tail);
    chk("rnd_head_id", head_id, mq.size() > 0 ? mq[0].idx : m_tail);
    if (rv) chk("rnd_retire_data", retire_data, mq[0].data);
  endtask

  task automatic drive(input bit r, input bit av, input bit wv, input int widx,
                       input logic [31:0] wd, input bit rr);
    rst = r; alloc_valid = av; wb_valid = wv; wb_idx = IW'(widx);
    wb_data = wd; retire_ready = rr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("reset_alloc_ready", alloc_ready, 1);
    chk("reset_alloc_idx", alloc_idx, 0);
    chk("reset_retire_valid", retire_valid, 0);
    chk("reset_retire_idx", retire_idx, 0);
    chk("reset_retire_data", retire_data, 0);
    chk("reset_count", count, 0);

    // in-order allocate, out-of-order write-back, in-order retire
    vecs.push_back(mk(0,1,0,0,0,0,      1,1,0,0,0,1,8'h01,8'h00));
    vecs.push_back(mk(0,1,0,0,0,0,      1,2,0,0,0,2,8'h03,8'h00));
    vecs.push_back(mk(0,1,0,0,0,0,      1,3,0,0,0,3,8'h07,8'h00));
    vecs.push_back(mk(0,0,1,2,32'hC,1,  1,3,0,0,0,3,8'h07,8'h04));
    vecs.push_back(mk(0,0,1,1,32'hB,1,  1,3,0,0,0,3,8'h07,8'h06));
    vecs.push_back(mk(0,0,1,0,32'hA,1,  1,3,1,0,32'hA,3,8'h07,8'h07));
    vecs.push_back(mk(0,0,0,0,0,1,      1,3,1,1,32'hB,2,8'h06,8'h06));
    vecs.push_back(mk(0,0,0,0,0,1,      1,3,1,2,32'hC,1,8'h04,8'h04));
    vecs.push_back(mk(0,0,0,0,0,1,      1,3,0,3,0,0,8'h00,8'h00));
    // fill, then retire while full with alloc_valid held
    vecs.push_back(mk(1,0,0,0,0,0,      1,0,0,0,0,0,8'h00,8'h00));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0,1,0,0,0,0, k < 8, k % 8, 0, 0, 0, k, 8'((1 << k) - 1), 8'h00));
    vecs.push_back(mk(0,1,1,0,32'h11,0, 0,0,1,0,32'h11,8,8'hFF,8'h01));
    vecs.push_back(mk(0,1,0,0,0,1,      1,0,0,1,0,7,8'hFE,8'h00));
    vecs.push_back(mk(0,1,0,0,0,0,      0,1,0,1,0,8,8'hFF,8'h00));
    // dropped write-backs: unallocated, duplicate, same-cycle allocation
    vecs.push_back(mk(1,0,0,0,0,0,      1,0,0,0,0,0,8'h00,8'h00));
    vecs.push_back(mk(0,1,0,0,0,0,      1,1,0,0,0,1,8'h01,8'h00));
    vecs.push_back(mk(0,0,1,5,32'h55,0, 1,1,0,0,0,1,8'h01,8'h00));
    vecs.push_back(mk(0,0,1,0,32'hA1,0, 1,1,1,0,32'hA1,1,8'h01,8'h01));
    vecs.push_back(mk(0,0,1,0,32'hB2,0, 1,1,1,0,32'hA1,1,8'h01,8'h01));
    vecs.push_back(mk(0,1,1,1,32'h77,0, 1,2,1,0,32'hA1,2,8'h03,8'h01));
    // stalled head stays valid and stable while allocations continue to full
    for (int k = 3; k <= 9; k++)
      vecs.push_back(mk(0,1,0,0,0,0, k < 8, (k > 8 ? 8 : k) % 8, 1, 0, 32'hA1,
                        (k > 8 ? 8 : k), 8'((1 << (k > 8 ? 8 : k)) - 1), 8'h01));
    // reset with live entries
    vecs.push_back(mk(1,0,0,0,0,0,      1,0,0,0,0,0,8'h00,8'h00));
    for (int k = 1; k <= 5; k++)
      vecs.push_back(mk(0,1,0,0,0,0, 1, k, 0, 0, 0, k, 8'((1 << k) - 1), 8'h00));
    vecs.push_back(mk(0,0,1,1,32'h1,0,  1,5,0,0,0,5,8'h1F,8'h02));
    vecs.push_back(mk(0,0,1,3,32'h3,0,  1,5,0,0,0,5,8'h1F,8'h0A));
    vecs.push_back(mk(1,1,0,0,0,1,      1,0,0,0,0,0,8'h00,8'h00));
    vecs.push_back(mk(0,1,0,0,0,0,      1,1,0,0,0,1,8'h01,8'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].av, vecs[i].wv, vecs[i].widx, vecs[i].wdata, vecs[i].rr);
      chk($sformatf("v%0d_alloc_ready", i), alloc_ready, vecs[i].ar);
      chk($sformatf("v%0d_alloc_idx", i), alloc_idx, vecs[i].aidx);
      chk($sformatf("v%0d_retire_valid", i), retire_valid, vecs[i].rv);
      chk($sformatf("v%0d_retire_idx", i), retire_idx, vecs[i].ridx);
      chk($sformatf("v%0d_head_id", i), head_id, vecs[i].ridx);
      chk($sformatf("v%0d_count", i), count, vecs[i].cnt);
      chk($sformatf("v%0d_entry_alloc", i), entry_alloc, vecs[i].ea);
      chk($sformatf("v%0d_entry_done", i), entry_done, vecs[i].ed);
      if (vecs[i].rv) chk($sformatf("v%0d_retire_data", i), retire_data, vecs[i].rdata);
      if (vecs[i].rst) chk($sformatf("v%0d_reset_data", i), retire_data, 0);
    end

    // randomized run against the reference model
    drive(1, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0);
    model_check();
    for (int c = 0; c < 3000; c++) begin
      bit r, av, wv, rr;
      int widx;
      logic [31:0] wd;
      r  = ($urandom % 250) == 0;
      av = $urandom % 2;
      wv = ($urandom % 4) != 0;
      rr = ($urandom % 4) != 0;
      wd = $urandom;
      if (mq.size() > 0 && ($urandom % 4) != 0)
        widx = mq[$urandom_range(0, mq.size() - 1)].idx;
      else
        widx = $urandom_range(0, D - 1);
      drive(r, av, wv, widx, wd, rr);
      model_step(r, av, wv, widx, wd, rr);
      model_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
